// File: rtl/uart_duty_rx.sv
// rtl/uart_duty_rx.sv - 8N1 UART receiver that parses {HEADER, duty} frames
// and holds the last accepted duty value for the PWM comparator.
module uart_duty_rx #(
  parameter int          CLKS_PER_BIT = 1042,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] duty_o,
  output logic       duty_valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
  } bit_state_t;

  typedef enum logic {
    F_WAIT_HDR, F_WAIT_DUTY
  } frame_state_t;

  logic [1:0]   sync_q;
  logic         rx_s;
  bit_state_t   state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]   idx_q;
  logic [7:0]   shift_q;
  logic         byte_good_q;
  logic         byte_err_q;
  logic         busy_q;

  frame_state_t fstate_q;
  logic [7:0]   duty_q;
  logic         duty_valid_q;
  logic         frame_err_q;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_i};
    end
  end

  // Counter is loaded with (wait - 1) and the sample happens when it hits 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      byte_good_q <= 1'b0;
      byte_err_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      byte_good_q <= 1'b0;
      byte_err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            cnt_q   <= HALF_CNT;
            state_q <= S_START;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (cnt_q == '0) begin
            if (!rx_s) begin
              cnt_q   <= FULL_CNT;
              idx_q   <= '0;
              state_q <= S_DATA;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == '0) begin
            shift_q <= {rx_s, shift_q[7:1]};
            cnt_q   <= FULL_CNT;
            if (idx_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_STOP: begin
          if (cnt_q == '0) begin
            if (rx_s) begin
              byte_good_q <= 1'b1;
              state_q     <= S_IDLE;
              busy_q      <= 1'b0;
            end else begin
              byte_err_q <= 1'b1;
              state_q    <= S_BREAK;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_BREAK: begin
          // A line held low yields a single error; wait for it to return high.
          if (rx_s) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fstate_q     <= F_WAIT_HDR;
      duty_q       <= 8'h00;
      duty_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      duty_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (byte_err_q) begin
        frame_err_q <= 1'b1;
        fstate_q    <= F_WAIT_HDR;
      end else if (byte_good_q) begin
        case (fstate_q)
          F_WAIT_HDR: begin
            if (shift_q == HEADER) fstate_q <= F_WAIT_DUTY;
          end
          F_WAIT_DUTY: begin
            duty_q       <= shift_q;
            duty_valid_q <= 1'b1;
            fstate_q     <= F_WAIT_HDR;
          end
          default: fstate_q <= F_WAIT_HDR;
        endcase
      end
    end
  end

  assign duty_o       = duty_q;
  assign duty_valid_o = duty_valid_q;
  assign frame_err_o  = frame_err_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_uart_duty_rx.sv
// tb/tb_uart_duty_rx.sv - randomized self-checking bench for uart_duty_rx
// against a frame-level reference model.
module tb_uart_duty_rx;

  localparam int C = 16;
  localparam logic [7:0] HDR = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_i = 1'b1;
  logic [7:0] duty_o;
  logic       duty_valid_o;
  logic       frame_err_o;
  logic       busy_o;

  int tests = 0;
  int fails = 0;

  int cyc = 0;
  int vcnt = 0;
  int ecnt = 0;
  int last_cyc = 0;
  logic [7:0] last_duty = 8'h00;

  // Reference model state
  bit         m_hdr = 1'b0;
  logic [7:0] m_duty = 8'h00;
  int         m_vcnt = 0;
  int         m_ecnt = 0;

  uart_duty_rx #(.CLKS_PER_BIT(C), .HEADER(HDR)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_i         (rx_i),
    .duty_o       (duty_o),
    .duty_valid_o (duty_valid_o),
    .frame_err_o  (frame_err_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (duty_valid_o) begin
      vcnt      = vcnt + 1;
      last_cyc  = cyc;
      last_duty = duty_o;
    end
    if (frame_err_o) ecnt = ecnt + 1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) begin
      m_ecnt++;
      m_hdr = 1'b0;
    end else if (m_hdr) begin
      m_duty = b;
      m_vcnt++;
      m_hdr = 1'b0;
    end else if (b == HDR) begin
      m_hdr = 1'b1;
    end
  endtask

  task automatic model_reset();
    m_hdr  = 1'b0;
    m_duty = 8'h00;
  endtask

  task automatic drive_bit(input logic b);
    rx_i = b;
    repeat (C) @(posedge clk);
    #1;
  endtask

  // Returns the cycle count at which the start bit was driven.
  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap,
                           output int start_cyc);
    @(posedge clk); #1;
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    rx_i = 1'b1;
    repeat (gap) @(posedge clk);
    #1;
    model_byte(b, stop_ok);
  endtask

  task automatic settle();
    rx_i = 1'b1;
    repeat (2 * C) @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string name);
    tests++;
    if (duty_o !== m_duty) begin
      fails++;
      $display("FAIL %s duty_o: got %02h, required %02h", name, duty_o, m_duty);
    end
    tests++;
    if (vcnt !== m_vcnt) begin
      fails++;
      $display("FAIL %s valid pulses: got %0d, required %0d", name, vcnt, m_vcnt);
    end
    tests++;
    if (ecnt !== m_ecnt) begin
      fails++;
      $display("FAIL %s error pulses: got %0d, required %0d", name, ecnt, m_ecnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx_i  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    tests++;
    if (duty_o !== 8'h00 || duty_valid_o !== 1'b0 || frame_err_o !== 1'b0 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL reset outputs: got duty=%02h v=%b e=%b busy=%b, required 00 0 0 0",
               duty_o, duty_valid_o, frame_err_o, busy_o);
    end
    repeat (100 * C) @(posedge clk);
    #1;
    check_state("reset_idle");
  endtask

  task automatic test_valid_frame();
    int s0, s1, lat;
    send_byte(HDR, 1'b1, C, s0);
    @(posedge clk); #1;
    s1 = cyc;
    rx_i = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    tests++;
    if (busy_o !== 1'b1) begin
      fails++;
      $display("FAIL busy_during_byte: got %b, required 1", busy_o);
    end
    repeat (C - 6) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) drive_bit(i == 7);
    drive_bit(1'b1);
    model_byte(8'h80, 1'b1);
    settle();
    check_state("valid_frame");
    // rx_i fall -> 2 sync flops -> IDLE detect, then C/2 + 9C to stop sample, +1 to output.
    lat = last_cyc - s1;
    tests++;
    if (lat < (C / 2 + 9 * C + 1) || lat > (C / 2 + 9 * C + 6)) begin
      fails++;
      $display("FAIL valid_latency: got %0d cycles, required %0d..%0d", lat,
               C / 2 + 9 * C + 1, C / 2 + 9 * C + 6);
    end
    tests++;
    if (last_duty !== 8'h80) begin
      fails++;
      $display("FAIL valid_pulse_duty: got %02h, required 80", last_duty);
    end
  endtask

  task automatic test_bad_header();
    int s;
    send_byte(8'h5A, 1'b1, C, s);
    send_byte(8'h40, 1'b1, C, s);
    settle();
    check_state("bad_header");
    send_byte(HDR, 1'b1, 0, s);
    send_byte(HDR, 1'b1, C, s);
    settle();
    check_state("hdr_as_duty");
  endtask

  task automatic test_frame_error();
    int s;
    send_byte(HDR, 1'b1, C, s);
    send_byte(8'h10, 1'b0, C, s);
    settle();
    check_state("frame_error");
    send_byte(HDR, 1'b1, C, s);
    send_byte(8'h10, 1'b1, C, s);
    settle();
    check_state("after_error");
  endtask

  task automatic test_glitch_break();
    int s;
    @(posedge clk); #1;
    rx_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx_i = 1'b1;
    repeat (3 * C) @(posedge clk);
    #1;
    tests++;
    if (busy_o !== 1'b0) begin
      fails++;
      $display("FAIL glitch_busy: got %b, required 0", busy_o);
    end
    check_state("glitch");
    rx_i = 1'b0;
    repeat (30 * C) @(posedge clk);
    #1;
    model_byte(8'h00, 1'b0);
    settle();
    check_state("break");
    send_byte(HDR, 1'b1, C, s);
    send_byte(8'h3C, 1'b1, C, s);
    settle();
    check_state("after_break");
  endtask

  task automatic test_reset_mid_frame();
    int s;
    send_byte(HDR, 1'b1, C, s);
    @(posedge clk); #1;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    repeat (C / 3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    tests++;
    if (duty_o !== 8'h00 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_frame: got duty=%02h busy=%b, required 00 0", duty_o, busy_o);
    end
    rx_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    settle();
    send_byte(HDR, 1'b1, C, s);
    send_byte(8'hFF, 1'b1, C, s);
    settle();
    check_state("after_mid_reset");
  endtask

  task automatic test_back_to_back();
    int s;
    logic [7:0] b;
    bit ok;
    int gap;
    for (int f = 0; f < 14; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        b = 8'($urandom_range(0, 255));
        send_byte(b, 1'b1, 0, s);
      end
      if ($urandom_range(0, 3) != 0) send_byte(HDR, 1'b1, 0, s);
      b   = 8'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 7) != 0);
      gap = ok ? $urandom_range(0, 2 * C) : C + $urandom_range(0, C);
      send_byte(b, ok, gap, s);
    end
    settle();
    check_state("random_stream");
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_bad_header();
    test_frame_error();
    test_glitch_break();
    test_reset_mid_frame();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_duty_rx.md
# uart_duty_rx

Serial command receiver sitting directly upstream of the PWM generator. It receives 8N1 UART bytes on a single input pin, parses a two-byte command frame (header 0xA5, then duty byte), and holds the accepted duty value on an 8-bit output that drives the PWM comparator's duty input. The held value changes only on a complete, error-free frame, so the PWM never sees partial or corrupted updates.

## Interface
- CLKS_PER_BIT, default 1042: clock cycles per UART bit (10 MHz / 9600 baud); legal range 4..65535.
- HEADER, default 8'hA5: required first byte of a frame.

- clk  in  1  system clock, rising-edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- rx_i  in  1  UART line, idle high, asynchronous to clk.
- duty_o  out  8  last accepted duty value; feeds the PWM duty input.
- duty_valid_o  out  1  one-cycle pulse when duty_o is updated.
- frame_err_o  out  1  one-cycle pulse on a stop-bit error.
- busy_o  out  1  high while the bit-level FSM is not in IDLE.

## Operation
- rx_i passes through a 2-flop synchronizer (reset to 1). All logic uses the synchronized bit rx_s.
- Bit counter: $clog2(CLKS_PER_BIT) bits wide. Bit index: 3 bits. Shift register: 8 bits, LSB first.
- Bit FSM:
  - IDLE: on rx_s == 0, load counter and go to START.
  - START: wait CLKS_PER_BIT/2 cycles (integer divide), then sample. If 0, go to DATA. If 1, treat as a glitch and return to IDLE with no error.
  - DATA: every CLKS_PER_BIT cycles, shift in rx_s. After 8 samples, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample.
    - If 1: byte good; go to IDLE.
    - If 0: pulse frame_err_o, discard the byte, go to BREAK.
  - BREAK: stay until rx_s == 1, then go to IDLE. A held-low line therefore produces exactly one error.
- Frame FSM, advanced only on good-byte or error events:
  - WAIT_HDR: a good byte equal to HEADER moves to WAIT_DUTY. Any other byte is ignored.
  - WAIT_DUTY: any good byte, including 0xA5, is written to duty_o with a duty_valid_o pulse, then return to WAIT_HDR. A framing error returns to WAIT_HDR and leaves duty_o unchanged.
- No timeout between header and duty byte.

## Timing
- Reset values: duty_o = 8'h00 (PWM output low), duty_valid_o = 0, frame_err_o = 0, busy_o = 0. Both FSMs in their idle/WAIT_HDR states, counters 0, synchronizer = 1.
- Reset asserted mid-byte or mid-frame: everything aborts immediately, and the partial frame is lost.
- Synchronizer latency: 2 cycles from an rx_i edge to an rx_s edge.
- busy_o rises the cycle after IDLE sees rx_s == 0.
- The stop-bit sample point is CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the start edge is seen on rx_s.
- duty_o and duty_valid_o update on the clock edge following that sample. duty_valid_o is high for exactly 1 cycle.
- frame_err_o behaves the same way on a bad stop bit.
- Back-to-back bytes are accepted: IDLE can detect a new start bit on the cycle after the good-byte stop sample.
- Tolerates ±2% baud mismatch.

## Test plan
- Reset check: after rst_n release, outputs are 0 and duty_o = 0x00; rx_i held high for 100 bit times gives no pulses.
- Valid frame (CLKS_PER_BIT=16): send 0xA5 then 0x80 → one duty_valid_o pulse, duty_o = 0x80 at the stop-sample + 1 cycle, no frame_err_o.
- Bad header: send 0x5A, 0x40 → no update, duty_o still 0x80. Then send 0xA5, 0xA5 → duty_o = 0xA5.
- Framing error: send 0xA5, then a duty byte 0x10 with stop bit 0 → one frame_err_o pulse, duty_o unchanged. Then 0xA5, 0x10 → duty_o = 0x10.
- Glitch and break: a 3-cycle low pulse on rx_i gives no busy-completed byte and no error. Holding rx_i low for 30 bit times gives exactly one frame_err_o, and the next valid frame is accepted.
- Reset mid-frame: assert rst_n low during the duty byte's DATA phase → duty_o = 0x00 immediately. The following full frame 0xA5, 0xFF gives duty_o = 0xFF.
